mxbus_arbiter: RTL

- Two-master, one-slave MX bus arbiter.
- Lets the instruction BIU (m0) and the data BIU (m1) share one MX bus slave (s0, e.g. the unified RAM) on both its read and write channels.
- Read and write channels are arbitrated independently: round-robin, one transaction in flight per channel, with a per-channel completion watchdog.
- Sits between the BIUs and the memory slave in the core/memory test wrappers.

---
 rtl/mxbus_pkg.sv | 16 +
 rtl/mxbus_arb_chan.sv | 128 ++++++++++++
 rtl/mxbus_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mxbus_pkg.sv
// Shared types and constants for the two-master MX bus arbiter.
//   arb_state_e  : per-channel arbitration state (IDLE, REQ, BUSY)
//   NUM_MASTERS  : number of arbitrated masters
//   WDOG_WIDTH   : width of the per-channel completion watchdog counter
package mxbus_pkg;

    localparam int unsigned NUM_MASTERS = 2;
    localparam int unsigned WDOG_WIDTH  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mxbus_arb_chan.sv
// One arbitrated MX bus channel: round-robin grant between two masters, a single
// transaction in flight, and a completion watchdog.
//   clk, rst            : clock, asynchronous active-low reset
//   req                 : txn_start of m1/m0
//   m0_payload/m1_...   : address (and write data) of each master
//   s_ack/s_cpl/s_ready : slave responses
//   s_start/s_payload   : request forwarded to the slave
//   m_ack/m_cpl/m_ready : slave responses routed to the granted master
//   grant               : one-hot owner, 00 when idle
//   timeout             : one-cycle pulse when the watchdog aborts a transaction
module mxbus_arb_chan
    import mxbus_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH  = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_MASTERS-1:0]   req,
    input  logic [PAYLOAD_WIDTH-1:0] m0_payload,
    input  logic [PAYLOAD_WIDTH-1:0] m1_payload,
    input  logic                     s_ack,
    input  logic                     s_cpl,
    input  logic                     s_ready,
    output logic                     s_start,
    output logic [PAYLOAD_WIDTH-1:0] s_payload,
    output logic [NUM_MASTERS-1:0]   m_ack,
    output logic [NUM_MASTERS-1:0]   m_cpl,
    output logic [NUM_MASTERS-1:0]   m_ready,
    output logic [NUM_MASTERS-1:0]   grant,
    output logic                     timeout
);

    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);
    // Abort fires on the edge where the counter would reach TIMEOUT_CYCLES.
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    arb_state_e            state;
    logic                  prio;       // 0: m0 wins a tie, 1: m1 wins a tie
    logic [WDOG_WIDTH-1:0] wdog_cnt;
    logic                  owner_req;
    logic                  fwd;
    logic                  wdog_hit;
    logic                  pick_m1;

    always_comb begin
        owner_req = |(grant & req);
        // A master that dropped its request in REQ gets nothing forwarded.
        fwd       = (state == BUSY) || ((state == REQ) && owner_req);
        wdog_hit  = WDOG_EN && (wdog_cnt == WDOG_LAST);
        pick_m1   = (&req) ? prio : req[1];
        s_start   = (state == REQ) && owner_req;
        s_payload = '0;
        if (state == REQ) begin
            if (grant[0]) begin
                s_payload = m0_payload;
            end else if (grant[1]) begin
                s_payload = m1_payload;
            end
        end
        m_ack   = fwd ? (grant & {NUM_MASTERS{s_ack}})   : '0;
        m_cpl   = fwd ? (grant & {NUM_MASTERS{s_cpl}})   : '0;
        m_ready = fwd ? (grant & {NUM_MASTERS{s_ready}}) : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            prio     <= 1'b0;
            wdog_cnt <= '0;
            grant    <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state    <= REQ;
                        wdog_cnt <= '0;
                        grant    <= pick_m1 ? 2'b10 : 2'b01;
                    end
                end
                REQ: begin
                    if (!owner_req) begin
                        // Protocol abort: leave prio alone.
                        state <= IDLE;
                        grant <= '0;
                    end else if (s_ack && s_cpl) begin
                        state <= IDLE;
                        grant <= '0;
                        prio  <= grant[0];
                    end else if (wdog_hit) begin
                        state   <= IDLE;
                        grant   <= '0;
                        prio    <= grant[0];
                        timeout <= 1'b1;
                    end else begin
                        if (s_ack) begin
                            state <= BUSY;
                        end
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                BUSY: begin
                    // cpl beats a simultaneous watchdog expiry.
                    if (s_cpl) begin
                        state <= IDLE;
                        grant <= '0;
                        prio  <= grant[0];
                    end else if (wdog_hit) begin
                        state   <= IDLE;
                        grant   <= '0;
                        prio    <= grant[0];
                        timeout <= 1'b1;
                    end else begin
                        wdog_cnt <= wdog_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mxbus_arbiter.sv
// Two-master, one-slave MX bus arbiter. The instruction BIU (m0) and data BIU (m1)
// share slave s0; read and write channels are arbitrated independently.
//   clk, rst                         : clock, asynchronous active-low reset
//   m{0,1}_{rd,wr}_txn_start/_addr   : master requests; m{0,1}_wr_data write data
//   m{0,1}_{rd,wr}_txn_ack/_cpl/_rdy : slave responses routed to the owner
//   m{0,1}_rd_data                   : s0_rd_data for the read owner, else 0
//   s0_*                             : forwarded requests / slave responses
//   {rd,wr}_grant                    : one-hot channel owner, 00 when idle
//   {rd,wr}_timeout                  : watchdog abort pulse
module mxbus_arbiter
    import mxbus_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_rd_txn_start,
    input  logic [ADDR_WIDTH-1:0] m0_rd_addr,
    output logic                  m0_rd_txn_ack,
    output logic                  m0_rd_txn_cpl,
    output logic                  m0_rd_ready,
    output logic [DATA_WIDTH-1:0] m0_rd_data,
    input  logic                  m1_rd_txn_start,
    input  logic [ADDR_WIDTH-1:0] m1_rd_addr,
    output logic                  m1_rd_txn_ack,
    output logic                  m1_rd_txn_cpl,
    output logic                  m1_rd_ready,
    output logic [DATA_WIDTH-1:0] m1_rd_data,
    input  logic                  m0_wr_txn_start,
    input  logic [ADDR_WIDTH-1:0] m0_wr_addr,
    input  logic [DATA_WIDTH-1:0] m0_wr_data,
    output logic                  m0_wr_txn_ack,
    output logic                  m0_wr_txn_cpl,
    output logic                  m0_wr_ready,
    input  logic                  m1_wr_txn_start,
    input  logic [ADDR_WIDTH-1:0] m1_wr_addr,
    input  logic [DATA_WIDTH-1:0] m1_wr_data,
    output logic                  m1_wr_txn_ack,
    output logic                  m1_wr_txn_cpl,
    output logic                  m1_wr_ready,
    output logic                  s0_rd_txn_start,
    output logic [ADDR_WIDTH-1:0] s0_rd_addr,
    input  logic                  s0_rd_txn_ack,
    input  logic                  s0_rd_txn_cpl,
    input  logic                  s0_rd_ready,
    input  logic [DATA_WIDTH-1:0] s0_rd_data,
    output logic                  s0_wr_txn_start,
    output logic [ADDR_WIDTH-1:0] s0_wr_addr,
    output logic [DATA_WIDTH-1:0] s0_wr_data,
    input  logic                  s0_wr_txn_ack,
    input  logic                  s0_wr_txn_cpl,
    input  logic                  s0_wr_ready,
    output logic [1:0]            rd_grant,
    output logic [1:0]            wr_grant,
    output logic                  rd_timeout,
    output logic                  wr_timeout
);

    localparam int unsigned WR_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    logic [NUM_MASTERS-1:0] rd_ack, rd_cpl, rd_rdy;
    logic [NUM_MASTERS-1:0] wr_ack, wr_cpl, wr_rdy;
    logic [WR_WIDTH-1:0]    wr_payload;

    mxbus_arb_chan #(
        .PAYLOAD_WIDTH (ADDR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rd_chan (
        .clk       (clk),
        .rst       (rst),
        .req       ({m1_rd_txn_start, m0_rd_txn_start}),
        .m0_payload(m0_rd_addr),
        .m1_payload(m1_rd_addr),
        .s_ack     (s0_rd_txn_ack),
        .s_cpl     (s0_rd_txn_cpl),
        .s_ready   (s0_rd_ready),
        .s_start   (s0_rd_txn_start),
        .s_payload (s0_rd_addr),
        .m_ack     (rd_ack),
        .m_cpl     (rd_cpl),
        .m_ready   (rd_rdy),
        .grant     (rd_grant),
        .timeout   (rd_timeout)
    );

    mxbus_arb_chan #(
        .PAYLOAD_WIDTH (WR_WIDTH),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wr_chan (
        .clk       (clk),
        .rst       (rst),
        .req       ({m1_wr_txn_start, m0_wr_txn_start}),
        .m0_payload({m0_wr_addr, m0_wr_data}),
        .m1_payload({m1_wr_addr, m1_wr_data}),
        .s_ack     (s0_wr_txn_ack),
        .s_cpl     (s0_wr_txn_cpl),
        .s_ready   (s0_wr_ready),
        .s_start   (s0_wr_txn_start),
        .s_payload (wr_payload),
        .m_ack     (wr_ack),
        .m_cpl     (wr_cpl),
        .m_ready   (wr_rdy),
        .grant     (wr_grant),
        .timeout   (wr_timeout)
    );

    assign s0_wr_addr = wr_payload[WR_WIDTH-1:DATA_WIDTH];
    assign s0_wr_data = wr_payload[DATA_WIDTH-1:0];

    assign m0_rd_txn_ack = rd_ack[0];
    assign m1_rd_txn_ack = rd_ack[1];
    assign m0_rd_txn_cpl = rd_cpl[0];
    assign m1_rd_txn_cpl = rd_cpl[1];
    assign m0_rd_ready   = rd_rdy[0];
    assign m1_rd_ready   = rd_rdy[1];
    assign m0_rd_data    = rd_grant[0] ? s0_rd_data : '0;
    assign m1_rd_data    = rd_grant[1] ? s0_rd_data : '0;

    assign m0_wr_txn_ack = wr_ack[0];
    assign m1_wr_txn_ack = wr_ack[1];
    assign m0_wr_txn_cpl = wr_cpl[0];
    assign m1_wr_txn_cpl = wr_cpl[1];
    assign m0_wr_ready   = wr_rdy[0];
    assign m1_wr_ready   = wr_rdy[1];

endmodule
